// File: rtl/utils_pkg.sv
// Shared core-bus types: request/response bundles, byte strobes, response codes.
// Also holds the address-window test used by bus responders.
package utils_pkg;

    localparam int CB_AW = 32;
    localparam int CB_DW = 32;

    typedef logic [CB_DW/8-1:0] cb_strb_t;

    typedef enum logic [1:0] {
        CB_OKAY   = 2'b00,
        CB_SLVERR = 2'b10
    } cb_resp_t;

    typedef struct packed {
        logic [CB_AW-1:0] rd_addr;
        logic [1:0]       rd_size;
        logic             rd_addr_valid;
        logic             rd_ready;
        logic [CB_AW-1:0] wr_addr;
        logic [1:0]       wr_size;
        logic             wr_addr_valid;
        logic [CB_DW-1:0] wr_data;
        cb_strb_t         wr_strobe;
        logic             wr_data_valid;
        logic             wr_resp_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic             rd_addr_ready;
        logic             rd_valid;
        logic [CB_DW-1:0] rd_data;
        cb_resp_t         rd_resp;
        logic             wr_addr_ready;
        logic             wr_data_ready;
        logic             wr_resp_valid;
        cb_resp_t         wr_resp_error;
    } s_cb_miso_t;

    // Offset is taken 33 bits wide so addresses below the base wrap negative.
    function automatic logic in_window(
        input logic [CB_AW-1:0] addr,
        input logic [CB_AW-1:0] base,
        input logic [CB_AW:0]   span
    );
        logic [CB_AW:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return !off[CB_AW] && (off < span);
    endfunction

endpackage

// File: rtl/cb_ram_slave_if.sv
// Core-bus port bundle: master drives requests, slave drives responses.
interface cb_ram_slave_if;
    import utils_pkg::*;

    s_cb_mosi_t cb_mosi_i;
    s_cb_miso_t cb_miso_o;

    modport master (
        output cb_mosi_i,
        input  cb_miso_o
    );

    modport slave (
        input  cb_mosi_i,
        output cb_miso_o
    );

endinterface

// File: rtl/cb_ram_array.sv
// Word-organised storage: asynchronous read port, byte-enable write port.
module cb_ram_array
    import utils_pkg::*;
#(
    parameter int unsigned SIZE_WORDS = 1024
) (
    input  logic                          clk,
    input  logic [$clog2(SIZE_WORDS)-1:0] rd_idx,
    output logic [31:0]                   rd_word,
    input  logic                          wr_en,
    input  logic [$clog2(SIZE_WORDS)-1:0] wr_idx,
    input  cb_strb_t                      wr_be,
    input  logic [31:0]                   wr_word
);

    logic [31:0] mem [SIZE_WORDS];

    assign rd_word = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/cb_ram_slave.sv
// Core-bus RAM responder: independent read and write channels, optional
// read wait states, SLVERR on accesses outside the address window.
module cb_ram_slave
    import utils_pkg::*;
#(
    parameter int unsigned SIZE_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned RD_WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    cb_ram_slave_if.slave bus
);

    localparam int          AW        = $clog2(SIZE_WORDS);
    localparam logic [32:0] SPAN      = 33'(SIZE_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(RD_WAIT_CYCLES);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_RESP
    } rd_state_t;

    s_cb_mosi_t mosi;
    s_cb_miso_t miso;

    rd_state_t   state_q;
    rd_state_t   state_d;
    logic [3:0]  wait_q;
    logic [3:0]  wait_d;
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;
    cb_resp_t    rd_resp_q;
    cb_resp_t    rd_resp_d;
    logic        rd_addr_ready;
    logic        ar_hs;
    logic        ar_ok;
    logic [31:0] ram_rdata;

    logic          aw_pending_q;
    logic          aw_ok_q;
    logic [AW-1:0] aw_idx_q;
    logic          wr_resp_valid_q;
    cb_resp_t      wr_resp_q;
    logic          wr_addr_ready;
    logic          wr_data_ready;
    logic          aw_hs;
    logic          w_hs;

    logic unused_sizes;

    assign mosi = bus.cb_mosi_i;
    assign unused_sizes = ^{mosi.rd_size, mosi.wr_size};

    // Read channel
    assign rd_addr_ready = (state_q == RD_IDLE)
                         || ((state_q == RD_RESP) && mosi.rd_ready);
    assign ar_hs = mosi.rd_addr_valid && rd_addr_ready;
    assign ar_ok = in_window(mosi.rd_addr, BASE_ADDR, SPAN);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rd_data_d = rd_data_q;
        rd_resp_d = rd_resp_q;
        case (state_q)
            RD_IDLE: ;
            RD_WAIT: begin
                if (wait_q == 4'd1) begin
                    state_d = RD_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (mosi.rd_ready) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
        // A new address overrides the idle/retire decision above.
        if (ar_hs) begin
            rd_data_d = ar_ok ? ram_rdata : 32'h0;
            rd_resp_d = ar_ok ? CB_OKAY : CB_SLVERR;
            if (RD_WAIT_CYCLES == 0) begin
                state_d = RD_RESP;
            end else begin
                state_d = RD_WAIT;
                wait_d  = WAIT_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RD_IDLE;
            wait_q    <= 4'd0;
            rd_data_q <= 32'h0;
            rd_resp_q <= CB_OKAY;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rd_data_q <= rd_data_d;
            rd_resp_q <= rd_resp_d;
        end
    end

    // Write channel: one buffered address, data strictly after it.
    assign wr_data_ready = aw_pending_q
                         && !(wr_resp_valid_q && !mosi.wr_resp_ready);
    assign w_hs          = mosi.wr_data_valid && wr_data_ready;
    assign wr_addr_ready = !aw_pending_q || w_hs;
    assign aw_hs         = mosi.wr_addr_valid && wr_addr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_pending_q    <= 1'b0;
            aw_ok_q         <= 1'b0;
            aw_idx_q        <= '0;
            wr_resp_valid_q <= 1'b0;
            wr_resp_q       <= CB_OKAY;
        end else begin
            if (aw_hs) begin
                aw_pending_q <= 1'b1;
                aw_ok_q      <= in_window(mosi.wr_addr, BASE_ADDR, SPAN);
                aw_idx_q     <= mosi.wr_addr[AW+1:2];
            end else if (w_hs) begin
                aw_pending_q <= 1'b0;
            end
            if (w_hs) begin
                wr_resp_valid_q <= 1'b1;
                wr_resp_q       <= aw_ok_q ? CB_OKAY : CB_SLVERR;
            end else if (mosi.wr_resp_ready) begin
                wr_resp_valid_q <= 1'b0;
            end
        end
    end

    cb_ram_array #(
        .SIZE_WORDS (SIZE_WORDS)
    ) u_array (
        .clk     (clk),
        .rd_idx  (mosi.rd_addr[AW+1:2]),
        .rd_word (ram_rdata),
        .wr_en   (w_hs && aw_ok_q),
        .wr_idx  (aw_idx_q),
        .wr_be   (mosi.wr_strobe),
        .wr_word (mosi.wr_data)
    );

    always_comb begin
        miso               = '0;
        miso.rd_addr_ready = rd_addr_ready;
        miso.rd_valid      = (state_q == RD_RESP);
        miso.rd_data       = rd_data_q;
        miso.rd_resp       = rd_resp_q;
        miso.wr_addr_ready = wr_addr_ready;
        miso.wr_data_ready = wr_data_ready;
        miso.wr_resp_valid = wr_resp_valid_q;
        miso.wr_resp_error = wr_resp_q;
    end

    assign bus.cb_miso_o = miso;

endmodule

// File: tb/tb_cb_ram_slave.sv
// Bench for cb_ram_slave: zero-wait instance on a scoreboard, plus a
// three-wait-state instance sharing its write traffic.
module tb_cb_ram_slave;
    import utils_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        cb_strb_t    strb;
        cb_resp_t    wresp;
        logic [31:0] rdata;
        cb_resp_t    rresp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        cb_resp_t    resp;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cb_ram_slave_if ifc0 ();
    cb_ram_slave_if ifc3 ();

    logic        rd3_valid;
    logic        rd3_ready;
    logic [31:0] rd3_addr;

    always_comb begin
        ifc3.cb_mosi_i               = ifc0.cb_mosi_i;
        ifc3.cb_mosi_i.rd_addr_valid = rd3_valid;
        ifc3.cb_mosi_i.rd_addr       = rd3_addr;
        ifc3.cb_mosi_i.rd_ready      = rd3_ready;
    end

    cb_ram_slave #(
        .SIZE_WORDS     (1024),
        .BASE_ADDR      (32'h0),
        .RD_WAIT_CYCLES (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (ifc0)
    );

    cb_ram_slave #(
        .SIZE_WORDS     (1024),
        .BASE_ADDR      (32'h0),
        .RD_WAIT_CYCLES (3)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifc3)
    );

    int   tests;
    int   fails;
    int   cyc;
    bit   ar_hs;
    bit   aw_hs;
    bit   w_hs;
    exp_t rq[$];
    exp_t wq[$];
    vec_t vecs[10];
    logic [31:0] b2b_d[3];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock: observe at the falling edge, retire responses, then
    // return just after the next rising edge for the driver.
    task automatic step();
        exp_t e;
        @(negedge clk);
        ar_hs = ifc0.cb_mosi_i.rd_addr_valid && ifc0.cb_miso_o.rd_addr_ready;
        aw_hs = ifc0.cb_mosi_i.wr_addr_valid && ifc0.cb_miso_o.wr_addr_ready;
        w_hs  = ifc0.cb_mosi_i.wr_data_valid && ifc0.cb_miso_o.wr_data_ready;
        if (ifc0.cb_miso_o.rd_valid && ifc0.cb_mosi_i.rd_ready) begin
            check("rd_expected", 32'(rq.size() != 0), 32'd1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                check("rd_data", ifc0.cb_miso_o.rd_data, e.data);
                check("rd_resp", 32'(ifc0.cb_miso_o.rd_resp), 32'(e.resp));
                check("rd_cycle", cyc, e.cyc);
            end
        end
        if (ifc0.cb_miso_o.wr_resp_valid && ifc0.cb_mosi_i.wr_resp_ready) begin
            check("wr_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                check("wr_resp", 32'(ifc0.cb_miso_o.wr_resp_error), 32'(e.resp));
                check("wr_cycle", cyc, e.cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input cb_strb_t s, input cb_resp_t er);
        int n;
        ifc0.cb_mosi_i.wr_addr       = a;
        ifc0.cb_mosi_i.wr_addr_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!aw_hs && n < 20);
        check("wr_addr_hs", 32'(aw_hs), 32'd1);
        ifc0.cb_mosi_i.wr_addr_valid = 1'b0;
        wq.push_back('{data: 32'h0, resp: er, cyc: cyc + 1});
        ifc0.cb_mosi_i.wr_data       = d;
        ifc0.cb_mosi_i.wr_strobe     = s;
        ifc0.cb_mosi_i.wr_data_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!w_hs && n < 20);
        check("wr_data_hs", 32'(w_hs), 32'd1);
        ifc0.cb_mosi_i.wr_data_valid = 1'b0;
        step();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                           input cb_resp_t er);
        int n;
        ifc0.cb_mosi_i.rd_addr       = a;
        ifc0.cb_mosi_i.rd_addr_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!ar_hs && n < 20);
        check("rd_addr_hs", 32'(ar_hs), 32'd1);
        ifc0.cb_mosi_i.rd_addr_valid = 1'b0;
        rq.push_back('{data: d, resp: er, cyc: cyc});
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{32'h10, 32'hDEADBEEF, 4'b1111, CB_OKAY, 32'hDEADBEEF, CB_OKAY};
        vecs[1] = '{32'h10, 32'h0000AB00, 4'b0010, CB_OKAY, 32'hDEADABEF, CB_OKAY};
        vecs[2] = '{32'h00, 32'h0BADC0DE, 4'b1111, CB_OKAY, 32'h0BADC0DE, CB_OKAY};
        vecs[3] = '{32'h1000, 32'h12345678, 4'b1111, CB_SLVERR, 32'h0, CB_SLVERR};
        vecs[4] = '{32'h00, 32'hFFFFFFFF, 4'b0000, CB_OKAY, 32'h0BADC0DE, CB_OKAY};
        vecs[5] = '{32'h14, 32'h11223344, 4'b1111, CB_OKAY, 32'h11223344, CB_OKAY};
        vecs[6] = '{32'h14, 32'hAABBCCDD, 4'b0101, CB_OKAY, 32'h11BB33DD, CB_OKAY};
        vecs[7] = '{32'hFFC, 32'hCAFEF00D, 4'b1111, CB_OKAY, 32'hCAFEF00D, CB_OKAY};
        vecs[8] = '{32'hFFFFFFFC, 32'h0, 4'b1111, CB_SLVERR, 32'h0, CB_SLVERR};
        vecs[9] = '{32'hFFC, 32'h0, 4'b0000, CB_OKAY, 32'hCAFEF00D, CB_OKAY};
        b2b_d[0] = 32'hA0A0A0A0;
        b2b_d[1] = 32'hB1B1B1B1;
        b2b_d[2] = 32'hC2C2C2C2;
        tests = 0;
        fails = 0;
        cyc   = 0;

        ifc0.cb_mosi_i = '0;
        rd3_valid = 1'b0;
        rd3_addr  = 32'h0;
        rd3_ready = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rd_valid", 32'(ifc0.cb_miso_o.rd_valid), 32'd0);
        check("rst_wr_resp_valid", 32'(ifc0.cb_miso_o.wr_resp_valid), 32'd0);
        check("rst_wr_data_ready", 32'(ifc0.cb_miso_o.wr_data_ready), 32'd0);
        check("rst_rd_data", ifc0.cb_miso_o.rd_data, 32'h0);
        check("rst_rd_resp", 32'(ifc0.cb_miso_o.rd_resp), 32'(CB_OKAY));
        check("rst_wr_resp_err", 32'(ifc0.cb_miso_o.wr_resp_error), 32'(CB_OKAY));
        check("rst_rd_addr_ready", 32'(ifc0.cb_miso_o.rd_addr_ready), 32'd1);
        check("rst_wr_addr_ready", 32'(ifc0.cb_miso_o.wr_addr_ready), 32'd1);
        check("rst_w3_rd_valid", 32'(ifc3.cb_miso_o.rd_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifc0.cb_mosi_i.rd_ready      = 1'b1;
        ifc0.cb_mosi_i.wr_resp_ready = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].wresp);
            do_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
        end

        // Read and write of one word resolved in the same cycle.
        ifc0.cb_mosi_i.wr_addr       = 32'h14;
        ifc0.cb_mosi_i.wr_addr_valid = 1'b1;
        step();
        ifc0.cb_mosi_i.wr_addr_valid = 1'b0;
        wq.push_back('{data: 32'h0, resp: CB_OKAY, cyc: cyc + 1});
        ifc0.cb_mosi_i.wr_data       = 32'h77777777;
        ifc0.cb_mosi_i.wr_strobe     = 4'b1111;
        ifc0.cb_mosi_i.wr_data_valid = 1'b1;
        ifc0.cb_mosi_i.rd_addr       = 32'h14;
        ifc0.cb_mosi_i.rd_addr_valid = 1'b1;
        step();
        check("rw_same_ar_hs", 32'(ar_hs), 32'd1);
        check("rw_same_w_hs", 32'(w_hs), 32'd1);
        rq.push_back('{data: 32'h11BB33DD, resp: CB_OKAY, cyc: cyc});
        ifc0.cb_mosi_i.wr_data_valid = 1'b0;
        ifc0.cb_mosi_i.rd_addr_valid = 1'b0;
        step();
        step();
        do_read(32'h14, 32'h77777777, CB_OKAY);

        // Three wait states, response stalled by rd_ready.
        rd3_addr  = 32'h10;
        rd3_valid = 1'b1;
        #1;
        check("w3_addr_ready_idle", 32'(ifc3.cb_miso_o.rd_addr_ready), 32'd1);
        step();
        rd3_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("w3_valid_T%0d", k),
                  32'(ifc3.cb_miso_o.rd_valid), 32'(k == 4));
            if (k < 4) step();
        end
        for (int k = 0; k < 3; k++) begin
            check("w3_hold_valid", 32'(ifc3.cb_miso_o.rd_valid), 32'd1);
            check("w3_hold_data", ifc3.cb_miso_o.rd_data, 32'hDEADABEF);
            check("w3_hold_resp", 32'(ifc3.cb_miso_o.rd_resp), 32'(CB_OKAY));
            check("w3_addr_ready_busy", 32'(ifc3.cb_miso_o.rd_addr_ready), 32'd0);
            step();
        end
        rd3_ready = 1'b1;
        #1;
        check("w3_addr_ready_take", 32'(ifc3.cb_miso_o.rd_addr_ready), 32'd1);
        step();
        check("w3_retired", 32'(ifc3.cb_miso_o.rd_valid), 32'd0);

        // Reset while a read sits in RD_WAIT.
        rd3_ready = 1'b0;
        rd3_addr  = 32'h14;
        rd3_valid = 1'b1;
        step();
        rd3_valid = 1'b0;
        step();
        check("rst_mid_in_wait", 32'(ifc3.cb_miso_o.rd_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_rd_valid", 32'(ifc3.cb_miso_o.rd_valid), 32'd0);
        check("rst_mid_addr_ready", 32'(ifc3.cb_miso_o.rd_addr_ready), 32'd1);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rst_mid_no_resp", 32'(ifc3.cb_miso_o.rd_valid), 32'd0);
            check("rst_mid_idle", 32'(ifc3.cb_miso_o.rd_addr_ready), 32'd1);
        end
        rd3_ready = 1'b1;
        rd3_addr  = 32'h10;
        rd3_valid = 1'b1;
        step();
        rd3_valid = 1'b0;
        n = 0;
        while (!ifc3.cb_miso_o.rd_valid && n < 10) begin
            step();
            n++;
        end
        check("rst_keep_w3_lat", n, 32'd3);
        check("rst_keep_w3_data", ifc3.cb_miso_o.rd_data, 32'hDEADABEF);
        step();
        do_read(32'h14, 32'h77777777, CB_OKAY);

        // Back-to-back stores.
        ifc0.cb_mosi_i.wr_addr       = 32'h0;
        ifc0.cb_mosi_i.wr_addr_valid = 1'b1;
        #1;
        check("b2b_addr_ready0", 32'(ifc0.cb_miso_o.wr_addr_ready), 32'd1);
        check("b2b_no_early_data", 32'(ifc0.cb_miso_o.wr_data_ready), 32'd0);
        wq.push_back('{data: 32'h0, resp: CB_OKAY, cyc: cyc + 2});
        step();
        for (int k = 1; k <= 3; k++) begin
            ifc0.cb_mosi_i.wr_addr_valid = (k < 3);
            ifc0.cb_mosi_i.wr_addr       = 32'(4 * k);
            ifc0.cb_mosi_i.wr_data       = b2b_d[k-1];
            ifc0.cb_mosi_i.wr_strobe     = 4'b1111;
            ifc0.cb_mosi_i.wr_data_valid = 1'b1;
            #1;
            check("b2b_data_ready", 32'(ifc0.cb_miso_o.wr_data_ready), 32'd1);
            if (k < 3) begin
                check("b2b_addr_ready", 32'(ifc0.cb_miso_o.wr_addr_ready), 32'd1);
                wq.push_back('{data: 32'h0, resp: CB_OKAY, cyc: cyc + 2});
            end
            step();
        end
        ifc0.cb_mosi_i.wr_data_valid = 1'b0;
        step();
        step();

        // Response back-pressure blocks further write data.
        ifc0.cb_mosi_i.wr_resp_ready = 1'b0;
        ifc0.cb_mosi_i.wr_addr       = 32'hC;
        ifc0.cb_mosi_i.wr_addr_valid = 1'b1;
        step();
        ifc0.cb_mosi_i.wr_addr       = 32'h10;
        ifc0.cb_mosi_i.wr_data       = 32'h2468ACE0;
        ifc0.cb_mosi_i.wr_data_valid = 1'b1;
        #1;
        check("bp_data_ready", 32'(ifc0.cb_miso_o.wr_data_ready), 32'd1);
        check("bp_addr_ready", 32'(ifc0.cb_miso_o.wr_addr_ready), 32'd1);
        step();
        ifc0.cb_mosi_i.wr_addr_valid = 1'b0;
        ifc0.cb_mosi_i.wr_data       = 32'h13579BDF;
        for (int k = 0; k < 2; k++) begin
            check("bp_resp_valid", 32'(ifc0.cb_miso_o.wr_resp_valid), 32'd1);
            check("bp_resp_err", 32'(ifc0.cb_miso_o.wr_resp_error), 32'(CB_OKAY));
            check("bp_stall", 32'(ifc0.cb_miso_o.wr_data_ready), 32'd0);
            step();
        end
        ifc0.cb_mosi_i.wr_resp_ready = 1'b1;
        wq.push_back('{data: 32'h0, resp: CB_OKAY, cyc: cyc});
        wq.push_back('{data: 32'h0, resp: CB_OKAY, cyc: cyc + 1});
        #1;
        check("bp_release", 32'(ifc0.cb_miso_o.wr_data_ready), 32'd1);
        step();
        ifc0.cb_mosi_i.wr_data_valid = 1'b0;
        step();
        step();

        do_read(32'h0, 32'hA0A0A0A0, CB_OKAY);
        do_read(32'h4, 32'hB1B1B1B1, CB_OKAY);
        do_read(32'h8, 32'hC2C2C2C2, CB_OKAY);
        do_read(32'hC, 32'h2468ACE0, CB_OKAY);
        do_read(32'h10, 32'h13579BDF, CB_OKAY);
        step();
        check("sb_rd_drained", rq.size(), 32'd0);
        check("sb_wr_drained", wq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
